load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter: ADDR_WIDTH, 32, width of request and memory addresses.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port: req_valid  input  1  execute stage presents a load/store.
REQ-005 Port: req_ready  output  1  unit can accept a request.
REQ-006 Port: req_is_store  input  1  1 = store, 0 = load.
REQ-007 Port: req_funct3  input  3  load_store_funct3_t encoding.
REQ-008 Port: req_addr  input  ADDR_WIDTH  byte address.
REQ-009 Port: req_wdata  input  32  store data, right-aligned.
REQ-010 Port: mem_req  output  1  access request to data cache.
REQ-011 Port: mem_addr  output  ADDR_WIDTH  word-aligned address, low 2 bits 0.
REQ-012 Port: mem_write_en  output  1  store access.
REQ-013 Port: mem_byte_en  output  4  byte lanes written or read.
REQ-014 Port: mem_wdata  output  32  lane-replicated store data.
REQ-015 Port: mem_ack  input  1  cache completes the access this cycle.
REQ-016 Port: mem_rdata  input  32  read word, valid with mem_ack on loads.
REQ-017 Port: wb  output  33  write_back_t: load result data plus valid.
REQ-018 Port: store_done  output  1  one-cycle pulse at store completion.
REQ-019 Port: misaligned  output  1  one-cycle pulse on rejected misaligned access.

Function
REQ-020 FSM states IDLE, WAIT_MEM, RESP; req_ready SHALL be 1 only in IDLE.
REQ-021 On req_valid and req_ready, the unit SHALL register is_store, funct3, addr, and wdata, and enter WAIT_MEM the next cycle.
REQ-022 In WAIT_MEM, mem_req SHALL be 1 and mem_addr, mem_write_en, mem_byte_en, and mem_wdata SHALL be held stable until mem_ack.
REQ-023 mem_ack in WAIT_MEM SHALL move the FSM to RESP; mem_ack in the first WAIT_MEM cycle is legal (minimum latency is 2 cycles from accept to result).
REQ-024 mem_ack while not in WAIT_MEM SHALL be ignored.
REQ-025 Byte enables SHALL be: byte = 4'b0001 << addr[1:0]; halfword = 4'b0011 << {addr[1],1'b0}; word = 4'b1111.
REQ-026 Store data SHALL be: byte = {4{wdata[7:0]}}; halfword = {2{wdata[15:0]}}; word = wdata.
REQ-027 Load data SHALL be extracted from the addressed lane of mem_rdata, captured on mem_ack.
REQ-028 Extension: F3_BYTE and F3_HALFWORD are sign-extended; F3_BYTE_U and F3_HALFWORD_U are zero-extended.
REQ-029 Reserved funct3 values (011, 110, 111) SHALL behave as F3_WORD.
REQ-030 In RESP, wb.valid SHALL be 1 for exactly one cycle for loads only, with wb.data holding the formatted result.
REQ-031 In RESP, store_done SHALL be 1 for exactly one cycle for stores only.
REQ-032 The FSM SHALL return from RESP to IDLE unconditionally.
REQ-033 Outside RESP, wb.valid SHALL be 0 and wb.data SHALL hold its last value.

Reset
REQ-034 While rst_n is 0, the FSM SHALL be in IDLE and mem_req, mem_write_en, wb.valid, store_done, and misaligned SHALL be 0.
REQ-035 While rst_n is 0, mem_byte_en, mem_addr, mem_wdata, and wb.data SHALL be 0.
REQ-036 Reset asserted in WAIT_MEM or RESP SHALL abort the access immediately, with mem_req dropping asynchronously and no pulse emitted.
REQ-037 req_ready SHALL be 1 in the first cycle after reset release.

Configuration
REQ-038 Macro LSU_MISALIGN_TRAP_EN defined: halfword with addr[0]=1, or word with addr[1:0]!=0, SHALL skip WAIT_MEM, pulse misaligned in RESP, and issue no mem_req, wb.valid, or store_done.
REQ-039 Macro LSU_MISALIGN_TRAP_EN undefined: misaligned SHALL be tied 0, and offending low address bits SHALL be treated as 0 (halfword addr[0], word addr[1:0]).

Verification
REQ-040 Load byte: addr 0x1003, funct3 000, rdata 0x80AA5511, ack on 1st cycle -> mem_addr 0x1000, byte_en 1000, wb.data 0xFFFFFF80, wb.valid 2 cycles after accept.
REQ-041 Store halfword: addr 0x2002, wdata 0x1234BEEF, ack delayed 3 cycles -> byte_en 1100, mem_wdata 0xBEEFBEEF, fields stable throughout, single store_done pulse.
REQ-042 Load half unsigned: addr 0x0, rdata 0x0000F00D -> wb.data 0x0000F00D; same with funct3 001 and rdata 0x0000800D -> wb.data 0xFFFF800D.
REQ-043 Misaligned word load at addr 0x3001: with LSU_MISALIGN_TRAP_EN -> misaligned pulse, no mem_req; without -> mem_addr 0x3000, normal load.
REQ-044 Reset asserted during WAIT_MEM, then a late mem_ack after release -> mem_req 0 immediately, ack ignored, no wb.valid, req_ready 1.
REQ-045 Back-to-back requests with req_valid held -> second request accepted only after RESP, req_ready 0 during WAIT_MEM and RESP.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one load or store from execute, issues a single
// word-aligned access to the data cache, then returns a formatted load result
// (wb) or a store_done pulse. Three-state FSM: IDLE -> WAIT_MEM -> RESP -> IDLE.
//
// Handshake: a request transfers on a rising edge where req_valid && req_ready;
// req_ready is high only in IDLE. Toward the cache, mem_req stays high with all
// mem_* fields stable until the cycle in which mem_ack is sampled high.
//
// Optional feature macro: LSU_MISALIGN_TRAP_EN. When defined, misaligned
// halfword/word accesses are rejected with a one-cycle misaligned pulse and no
// cache access. When undefined, misaligned is tied 0 and the offending low
// address bits are ignored.

package load_store_unit_pkg;

    typedef enum logic [2:0] {
        F3_BYTE       = 3'b000,
        F3_HALFWORD   = 3'b001,
        F3_WORD       = 3'b010,
        F3_BYTE_U     = 3'b100,
        F3_HALFWORD_U = 3'b101
    } load_store_funct3_t;

    typedef struct packed {
        logic [31:0] data;
        logic        valid;
    } write_back_t;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_MEM = 2'd1,
        ST_RESP     = 2'd2
    } lsu_state_t;

    // Access size from funct3: 0 = byte, 1 = halfword, 2 = word.
    // Reserved encodings (011, 110, 111) fall into the word bucket via bit 1.
    function automatic logic [1:0] size_of(input logic [2:0] f3);
        if (f3[1]) begin
            return 2'd2;
        end else if (f3[0]) begin
            return 2'd1;
        end else begin
            return 2'd0;
        end
    endfunction

endpackage

module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_is_store,
    input  logic [2:0]            req_funct3,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_write_en,
    output logic [3:0]            mem_byte_en,
    output logic [31:0]           mem_wdata,
    input  logic                  mem_ack,
    input  logic [31:0]           mem_rdata,
    output write_back_t           wb,
    output logic                  store_done,
    output logic                  misaligned,
    output lsu_state_t            dbg_state
);

    lsu_state_t            state_q, state_d;
    logic                  is_store_q, is_store_d;
    logic [2:0]            funct3_q, funct3_d;
    logic [1:0]            addr_lo_q, addr_lo_d;
    logic                  mem_req_q, mem_req_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic                  mem_write_en_q, mem_write_en_d;
    logic [3:0]            mem_byte_en_q, mem_byte_en_d;
    logic [31:0]           mem_wdata_q, mem_wdata_d;
    logic                  wb_valid_q, wb_valid_d;
    logic [31:0]           wb_data_q, wb_data_d;
    logic                  store_done_q, store_done_d;
    logic                  misaligned_q, misaligned_d;

    logic [1:0]  req_size;
    logic [1:0]  req_lo;
    logic [3:0]  req_be;
    logic [31:0] req_wd;
    logic        req_mis;
    logic [31:0] lane;
    logic        load_signed;
    logic [31:0] load_fmt;

    // Decode the incoming request into effective lane offset, byte enables and replicated data.
    always_comb begin
        req_size = size_of(req_funct3);
        req_lo   = 2'b00;
        req_be   = 4'b1111;
        req_wd   = req_wdata;
        case (req_size)
            2'd0: begin
                req_lo = req_addr[1:0];
                req_be = 4'b0001 << req_addr[1:0];
                req_wd = {4{req_wdata[7:0]}};
            end
            2'd1: begin
                req_lo = {req_addr[1], 1'b0};
                req_be = 4'b0011 << {req_addr[1], 1'b0};
                req_wd = {2{req_wdata[15:0]}};
            end
            default: begin
            end
        endcase
    end

`ifdef LSU_MISALIGN_TRAP_EN
    // Flag halfword accesses on odd addresses and word accesses off a word boundary.
    always_comb begin
        req_mis = ((req_size == 2'd1) && req_addr[0]) ||
                  ((req_size == 2'd2) && (req_addr[1:0] != 2'b00));
    end
`else
    assign req_mis = 1'b0;
`endif

    // Shift the addressed lane down to bit 0 and apply sign or zero extension.
    always_comb begin
        lane        = mem_rdata >> {addr_lo_q, 3'b000};
        load_signed = ~funct3_q[2];
        case (size_of(funct3_q))
            2'd0:    load_fmt = {{24{load_signed & lane[7]}}, lane[7:0]};
            2'd1:    load_fmt = {{16{load_signed & lane[15]}}, lane[15:0]};
            default: load_fmt = lane;
        endcase
    end

    // Next-state and next-output logic for the access FSM.
    always_comb begin
        state_d        = state_q;
        is_store_d     = is_store_q;
        funct3_d       = funct3_q;
        addr_lo_d      = addr_lo_q;
        mem_req_d      = mem_req_q;
        mem_addr_d     = mem_addr_q;
        mem_write_en_d = mem_write_en_q;
        mem_byte_en_d  = mem_byte_en_q;
        mem_wdata_d    = mem_wdata_q;
        wb_data_d      = wb_data_q;
        wb_valid_d     = 1'b0;
        store_done_d   = 1'b0;
        misaligned_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    is_store_d    = req_is_store;
                    funct3_d      = req_funct3;
                    addr_lo_d     = req_lo;
                    mem_addr_d    = {req_addr[ADDR_WIDTH-1:2], 2'b00};
                    mem_byte_en_d = req_be;
                    mem_wdata_d   = req_wd;
                    if (req_mis) begin
                        // Rejected access: no cache request, only the trap pulse.
                        state_d      = ST_RESP;
                        misaligned_d = 1'b1;
                    end else begin
                        state_d        = ST_WAIT_MEM;
                        mem_req_d      = 1'b1;
                        mem_write_en_d = req_is_store;
                    end
                end
            end
            ST_WAIT_MEM: begin
                if (mem_ack) begin
                    state_d        = ST_RESP;
                    mem_req_d      = 1'b0;
                    mem_write_en_d = 1'b0;
                    if (is_store_q) begin
                        store_done_d = 1'b1;
                    end else begin
                        wb_valid_d = 1'b1;
                        wb_data_d  = load_fmt;
                    end
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any access in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            is_store_q     <= 1'b0;
            funct3_q       <= 3'b000;
            addr_lo_q      <= 2'b00;
            mem_req_q      <= 1'b0;
            mem_addr_q     <= '0;
            mem_write_en_q <= 1'b0;
            mem_byte_en_q  <= 4'b0000;
            mem_wdata_q    <= 32'h0;
            wb_valid_q     <= 1'b0;
            wb_data_q      <= 32'h0;
            store_done_q   <= 1'b0;
            misaligned_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            is_store_q     <= is_store_d;
            funct3_q       <= funct3_d;
            addr_lo_q      <= addr_lo_d;
            mem_req_q      <= mem_req_d;
            mem_addr_q     <= mem_addr_d;
            mem_write_en_q <= mem_write_en_d;
            mem_byte_en_q  <= mem_byte_en_d;
            mem_wdata_q    <= mem_wdata_d;
            wb_valid_q     <= wb_valid_d;
            wb_data_q      <= wb_data_d;
            store_done_q   <= store_done_d;
            misaligned_q   <= misaligned_d;
        end
    end

    assign req_ready    = (state_q == ST_IDLE);
    assign mem_req      = mem_req_q;
    assign mem_addr     = mem_addr_q;
    assign mem_write_en = mem_write_en_q;
    assign mem_byte_en  = mem_byte_en_q;
    assign mem_wdata    = mem_wdata_q;
    assign wb           = '{data: wb_data_q, valid: wb_valid_q};
    assign store_done   = store_done_q;
    assign misaligned   = misaligned_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed testbench for load_store_unit. Inputs change 1 ns after the rising
// edge; outputs are compared at that same point, away from the active edge.
// Build with +define+LSU_MISALIGN_TRAP_EN to exercise the trap variant.

module tb_load_store_unit;
    import load_store_unit_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_is_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_write_en;
    logic [3:0]  mem_byte_en;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    write_back_t wb;
    logic        store_done;
    logic        misaligned;
    lsu_state_t  dbg_state;

    int n_checks = 0;
    int n_pass   = 0;

    load_store_unit #(.ADDR_WIDTH(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_is_store (req_is_store),
        .req_funct3   (req_funct3),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .mem_write_en (mem_write_en),
        .mem_byte_en  (mem_byte_en),
        .mem_wdata    (mem_wdata),
        .mem_ack      (mem_ack),
        .mem_rdata    (mem_rdata),
        .wb           (wb),
        .store_done   (store_done),
        .misaligned   (misaligned),
        .dbg_state    (dbg_state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one request for one accepted cycle; returns 1 ns after the accept edge.
    task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd);
        req_valid    = 1'b1;
        req_is_store = st;
        req_funct3   = f3;
        req_addr     = a;
        req_wdata    = wd;
        tick();
        req_valid    = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 1'b0; req_is_store = 1'b0; req_funct3 = 3'b000;
        req_addr = 32'h0; req_wdata = 32'h0; mem_ack = 1'b0; mem_rdata = 32'h0;
        #2;
        n_checks++; if (mem_req !== 1'b0) $display("FAIL rst_mem_req: got %0b want 0", mem_req); else n_pass++;
        n_checks++; if (mem_write_en !== 1'b0) $display("FAIL rst_we: got %0b want 0", mem_write_en); else n_pass++;
        n_checks++; if ({store_done, misaligned, wb.valid} !== 3'b000) $display("FAIL rst_pulses: got %b want 000", {store_done, misaligned, wb.valid}); else n_pass++;
        n_checks++; if (mem_byte_en !== 4'b0000) $display("FAIL rst_be: got %b want 0000", mem_byte_en); else n_pass++;
        n_checks++; if ({mem_addr, mem_wdata, wb.data} !== 96'h0) $display("FAIL rst_data: addr %h wdata %h wb %h want 0", mem_addr, mem_wdata, wb.data); else n_pass++;
        n_checks++; if (dbg_state !== ST_IDLE) $display("FAIL rst_state: got %0d want %0d", dbg_state, ST_IDLE); else n_pass++;
        tick(); tick();
        rst_n = 1'b1;
        tick();
        n_checks++; if (req_ready !== 1'b1) $display("FAIL rst_ready_after_release: got %0b want 1", req_ready); else n_pass++;
    endtask

    // One complete load with ack in the first WAIT_MEM cycle.
    task automatic run_load(input string nm, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] rd, input logic [31:0] exp_addr,
                            input logic [3:0] exp_be, input logic [31:0] exp_data);
        issue(1'b0, f3, a, 32'h0);
        n_checks++; if (mem_req !== 1'b1 || mem_write_en !== 1'b0) $display("FAIL %s_req: req %0b we %0b want 1 0", nm, mem_req, mem_write_en); else n_pass++;
        n_checks++; if (mem_addr !== exp_addr) $display("FAIL %s_addr: got %h want %h", nm, mem_addr, exp_addr); else n_pass++;
        n_checks++; if (mem_byte_en !== exp_be) $display("FAIL %s_be: got %b want %b", nm, mem_byte_en, exp_be); else n_pass++;
        n_checks++; if (req_ready !== 1'b0) $display("FAIL %s_ready_wait: got %0b want 0", nm, req_ready); else n_pass++;
        mem_ack = 1'b1; mem_rdata = rd;
        tick();
        mem_ack = 1'b0; mem_rdata = 32'h0;
        n_checks++; if (wb.valid !== 1'b1 || store_done !== 1'b0) $display("FAIL %s_wb_valid: valid %0b sd %0b want 1 0", nm, wb.valid, store_done); else n_pass++;
        n_checks++; if (wb.data !== exp_data) $display("FAIL %s_wb_data: got %h want %h", nm, wb.data, exp_data); else n_pass++;
        n_checks++; if (mem_req !== 1'b0 || req_ready !== 1'b0) $display("FAIL %s_resp: req %0b ready %0b want 0 0", nm, mem_req, req_ready); else n_pass++;
        tick();
        n_checks++; if (wb.valid !== 1'b0 || req_ready !== 1'b1) $display("FAIL %s_after: valid %0b ready %0b want 0 1", nm, wb.valid, req_ready); else n_pass++;
        n_checks++; if (wb.data !== exp_data) $display("FAIL %s_wb_hold: got %h want %h", nm, wb.data, exp_data); else n_pass++;
    endtask

    task automatic test_load_byte();
        run_load("lb", 3'b000, 32'h0000_1003, 32'h80AA_5511, 32'h0000_1000, 4'b1000, 32'hFFFF_FF80);
    endtask

    task automatic test_load_ext();
        run_load("lhu",  3'b101, 32'h0000_0000, 32'h0000_F00D, 32'h0000_0000, 4'b0011, 32'h0000_F00D);
        run_load("lh",   3'b001, 32'h0000_0000, 32'h0000_800D, 32'h0000_0000, 4'b0011, 32'hFFFF_800D);
        run_load("lbu",  3'b100, 32'h0000_0005, 32'h1122_F344, 32'h0000_0004, 4'b0010, 32'h0000_00F3);
        run_load("lh_hi",3'b001, 32'h0000_0002, 32'h8001_1234, 32'h0000_0000, 4'b1100, 32'hFFFF_8001);
        run_load("rsv",  3'b111, 32'h0000_0008, 32'hDEAD_BEEF, 32'h0000_0008, 4'b1111, 32'hDEAD_BEEF);
        run_load("lw",   3'b010, 32'h0000_000C, 32'h1234_5678, 32'h0000_000C, 4'b1111, 32'h1234_5678);
    endtask

    task automatic test_store_half();
        issue(1'b1, 3'b001, 32'h0000_2002, 32'h1234_BEEF);
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (mem_req !== 1'b1 || mem_write_en !== 1'b1) $display("FAIL sh_req_c%0d: req %0b we %0b want 1 1", i, mem_req, mem_write_en); else n_pass++;
            n_checks++; if (mem_addr !== 32'h0000_2000 || mem_byte_en !== 4'b1100) $display("FAIL sh_addr_be_c%0d: addr %h be %b want 00002000 1100", i, mem_addr, mem_byte_en); else n_pass++;
            n_checks++; if (mem_wdata !== 32'hBEEF_BEEF) $display("FAIL sh_wdata_c%0d: got %h want beefbeef", i, mem_wdata); else n_pass++;
            n_checks++; if (store_done !== 1'b0 || dbg_state !== ST_WAIT_MEM) $display("FAIL sh_wait_c%0d: sd %0b state %0d want 0 %0d", i, store_done, dbg_state, ST_WAIT_MEM); else n_pass++;
            if (i == 3) mem_ack = 1'b1;
            tick();
        end
        mem_ack = 1'b0;
        n_checks++; if (store_done !== 1'b1 || wb.valid !== 1'b0) $display("FAIL sh_done: sd %0b valid %0b want 1 0", store_done, wb.valid); else n_pass++;
        n_checks++; if (mem_req !== 1'b0) $display("FAIL sh_req_resp: got %0b want 0", mem_req); else n_pass++;
        tick();
        n_checks++; if (store_done !== 1'b0 || req_ready !== 1'b1) $display("FAIL sh_after: sd %0b ready %0b want 0 1", store_done, req_ready); else n_pass++;
        tick();
        n_checks++; if (store_done !== 1'b0) $display("FAIL sh_single_pulse: got %0b want 0", store_done); else n_pass++;
    endtask

    task automatic test_store_byte();
        issue(1'b1, 3'b000, 32'h0000_0013, 32'h0000_00A5);
        n_checks++; if (mem_byte_en !== 4'b1000 || mem_addr !== 32'h0000_0010) $display("FAIL sb_be_addr: be %b addr %h want 1000 00000010", mem_byte_en, mem_addr); else n_pass++;
        n_checks++; if (mem_wdata !== 32'hA5A5_A5A5) $display("FAIL sb_wdata: got %h want a5a5a5a5", mem_wdata); else n_pass++;
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        n_checks++; if (store_done !== 1'b1) $display("FAIL sb_done: got %0b want 1", store_done); else n_pass++;
        tick();
    endtask

    task automatic test_misaligned();
`ifdef LSU_MISALIGN_TRAP_EN
        issue(1'b0, 3'b010, 32'h0000_3001, 32'h0);
        n_checks++; if (misaligned !== 1'b1) $display("FAIL mis_pulse: got %0b want 1", misaligned); else n_pass++;
        n_checks++; if (mem_req !== 1'b0 || wb.valid !== 1'b0 || store_done !== 1'b0) $display("FAIL mis_no_access: req %0b valid %0b sd %0b want 0 0 0", mem_req, wb.valid, store_done); else n_pass++;
        tick();
        n_checks++; if (misaligned !== 1'b0 || req_ready !== 1'b1 || mem_req !== 1'b0) $display("FAIL mis_after: mis %0b ready %0b req %0b want 0 1 0", misaligned, req_ready, mem_req); else n_pass++;
`else
        run_load("mis_lw", 3'b010, 32'h0000_3001, 32'hCAFE_F00D, 32'h0000_3000, 4'b1111, 32'hCAFE_F00D);
        run_load("mis_lh", 3'b001, 32'h0000_3003, 32'h9ABC_0000, 32'h0000_3000, 4'b1100, 32'hFFFF_9ABC);
        n_checks++; if (misaligned !== 1'b0) $display("FAIL mis_tied: got %0b want 0", misaligned); else n_pass++;
`endif
    endtask

    task automatic test_reset_mid();
        issue(1'b0, 3'b010, 32'h0000_4000, 32'h0);
        n_checks++; if (mem_req !== 1'b1) $display("FAIL rm_req_before: got %0b want 1", mem_req); else n_pass++;
        rst_n = 1'b0;
        #1;
        n_checks++; if (mem_req !== 1'b0 || mem_addr !== 32'h0) $display("FAIL rm_async: req %0b addr %h want 0 0", mem_req, mem_addr); else n_pass++;
        n_checks++; if (wb.data !== 32'h0 || req_ready !== 1'b1) $display("FAIL rm_clear: wb %h ready %0b want 0 1", wb.data, req_ready); else n_pass++;
        tick();
        rst_n = 1'b1;
        mem_ack = 1'b1; mem_rdata = 32'h5555_AAAA;
        tick();
        mem_ack = 1'b0;
        n_checks++; if (wb.valid !== 1'b0 || wb.data !== 32'h0 || store_done !== 1'b0) $display("FAIL rm_late_ack: valid %0b data %h sd %0b want 0 0 0", wb.valid, wb.data, store_done); else n_pass++;
        n_checks++; if (req_ready !== 1'b1 || mem_req !== 1'b0) $display("FAIL rm_idle: ready %0b req %0b want 1 0", req_ready, mem_req); else n_pass++;
    endtask

    task automatic test_back_to_back();
        req_valid = 1'b1; req_is_store = 1'b0; req_funct3 = 3'b010; req_addr = 32'h0000_0040;
        tick();
        req_addr = 32'h0000_0080;
        n_checks++; if (req_ready !== 1'b0 || mem_addr !== 32'h0000_0040) $display("FAIL b2b_wait: ready %0b addr %h want 0 00000040", req_ready, mem_addr); else n_pass++;
        mem_ack = 1'b1; mem_rdata = 32'h0000_0A0A;
        tick();
        mem_ack = 1'b0;
        n_checks++; if (req_ready !== 1'b0 || wb.data !== 32'h0000_0A0A) $display("FAIL b2b_resp: ready %0b wb %h want 0 00000a0a", req_ready, wb.data); else n_pass++;
        tick();
        n_checks++; if (req_ready !== 1'b1 || mem_req !== 1'b0) $display("FAIL b2b_idle: ready %0b req %0b want 1 0", req_ready, mem_req); else n_pass++;
        tick();
        req_valid = 1'b0;
        n_checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h0000_0080) $display("FAIL b2b_second: req %0b addr %h want 1 00000080", mem_req, mem_addr); else n_pass++;
        mem_ack = 1'b1; mem_rdata = 32'h0000_0B0B;
        tick();
        mem_ack = 1'b0;
        n_checks++; if (wb.valid !== 1'b1 || wb.data !== 32'h0000_0B0B) $display("FAIL b2b_second_wb: valid %0b wb %h want 1 00000b0b", wb.valid, wb.data); else n_pass++;
        tick();
    endtask

    initial begin
        test_reset();
        test_load_byte();
        test_load_ext();
        test_store_half();
        test_store_byte();
        test_misaligned();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
